tod_counter: RTL and testbench
==============================

TOD_COUNTER -- requirements
Module: tod_counter

Interface
REQ-001 SHALL provide parameter TICKS_PER_SEC, default 50000000, clk cycles per second (legal range 2..2^26).
REQ-002 SHALL provide port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port run  input  1  1 = timekeeping advances, 0 = freeze.
REQ-005 SHALL provide port set_req  input  1  one-cycle load strobe for set_hh/set_mm/set_ss.
REQ-006 SHALL provide ports set_hh  input  5, set_mm  input  6, set_ss  input  6  binary load values.
REQ-007 SHALL provide ports set_ack  output  1 and set_err  output  1  one-cycle load accepted / rejected pulses.
REQ-008 SHALL provide ports hh  output  5, mm  output  6, ss  output  6  current time, binary, 24-hour.
REQ-009 SHALL provide port sec_pulse  output  1  one-cycle pulse per elapsed second.
REQ-010 SHALL provide port day_pulse  output  1  one-cycle pulse on midnight wrap; drives the `in` input of the downstream mod-7 weekday counter.
REQ-011 SHALL provide ports alarm_arm  input  1, alarm_hh  input  5, alarm_mm  input  6, alarm_hit  output  1.

Function
REQ-012 Prescaler SHALL count 0..TICKS_PER_SEC-1 only while run=1 and hold its value while run=0.
REQ-013 On the edge where prescaler=TICKS_PER_SEC-1 and run=1 (a "tick"), the prescaler SHALL return to 0, ss SHALL increment, and sec_pulse SHALL be registered high for exactly that following cycle.
REQ-014 ss SHALL wrap 59->0 with mm increment, mm SHALL wrap 59->0 with hh increment, hh SHALL wrap 23->0, all on the same tick edge.
REQ-015 day_pulse SHALL be high for exactly the one cycle in which outputs first read 00:00:00 after a tick from 23:59:59; otherwise 0.
REQ-016 sec_pulse, day_pulse, set_ack, set_err and alarm_hit SHALL all be registered; no combinational input-to-output path.
REQ-017 On set_req=1 with set_hh<24, set_mm<60, set_ss<60, the next edge SHALL load hh/mm/ss, clear the prescaler to 0, and pulse set_ack for one cycle.
REQ-018 On set_req=1 with any field out of range, the time and prescaler SHALL be unchanged and set_err SHALL pulse for one cycle.
REQ-019 A valid load SHALL take priority over a coincident tick; that tick is discarded and sec_pulse, day_pulse and alarm_hit stay 0 that cycle.
REQ-020 A load (including 00:00:00 and alarm time) SHALL never generate day_pulse or alarm_hit.
REQ-021 Loads SHALL be accepted regardless of run; set_req held high SHALL reload and ack every cycle.
REQ-022 Changing run mid-second SHALL resume from the retained prescaler value with no lost or extra tick.

Reset
REQ-023 rst_n low SHALL immediately set hh=mm=ss=0, prescaler=0, and sec_pulse=day_pulse=set_ack=set_err=alarm_hit=0.
REQ-024 Reset assertion mid-second or during set_req SHALL abort the operation; no pulse SHALL be emitted on the first edge after release unless caused by that edge's inputs.

Configuration
REQ-025 With macro TOD_ALARM_EN defined, alarm_hit SHALL pulse for one cycle when a tick produces hh=alarm_hh, mm=alarm_mm, ss=0 while alarm_arm=1.
REQ-026 Alarm comparison SHALL use alarm inputs sampled on the tick edge; alarm_hh>=24 or alarm_mm>=60 SHALL never hit.
REQ-027 Without TOD_ALARM_EN, alarm ports SHALL remain present, inputs SHALL be ignored, alarm_hit SHALL be constant 0, and no alarm logic SHALL be synthesised.

Verification (TICKS_PER_SEC=4)
REQ-028 Reset, run=1 for 12 clocks -> sec_pulse every 4th cycle, ss=3, mm=hh=0, day_pulse never high.
REQ-029 Load 23:59:58, run=1 -> after 8 clocks outputs 00:00:00, day_pulse high exactly that one cycle, sec_pulse coincident.
REQ-030 set_req with set_mm=60 -> set_err one cycle, time unchanged; set_req with 12:34:56 on the tick edge -> set_ack, time 12:34:56, prescaler 0, no sec_pulse.
REQ-031 run toggled 1->0 at prescaler=2 for 10 clocks then 1 -> next sec_pulse exactly 2 clocks after resume.
REQ-032 TOD_ALARM_EN defined, alarm 00:01 armed, load 00:00:59 -> alarm_hit one cycle at 00:01:00; disarmed or macro undefined -> alarm_hit stays 0.
REQ-033 rst_n asserted at 23:59:59, prescaler=3 -> outputs 0 immediately, no day_pulse after release.

Source files
------------

// File: rtl/tod_counter.sv
// Time-of-day counter: prescaled seconds, hh:mm:ss in 24-hour binary,
// synchronous load with range checking, second/day pulses and an
// optional one-shot alarm compare enabled by the TOD_ALARM_EN macro.
module tod_counter #(
  parameter int unsigned TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_req,
  input  logic [4:0] set_hh,
  input  logic [5:0] set_mm,
  input  logic [5:0] set_ss,
  output logic       set_ack,
  output logic       set_err,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       sec_pulse,
  output logic       day_pulse,
  input  logic       alarm_arm,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  output logic       alarm_hit
);

  localparam int unsigned PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic [4:0]    hh_d;
  logic [5:0]    mm_d;
  logic [5:0]    ss_d;
  logic          sec_d;
  logic          day_d;
  logic          ack_d;
  logic          err_d;
  logic          tick;
  logic          load_ok;

  // Next-state: a load (valid or not) owns the cycle; otherwise run advances time
  always_comb begin
    tick    = run && (pre_q == PRE_MAX);
    load_ok = set_req && (set_hh < 5'd24) && (set_mm < 6'd60) && (set_ss < 6'd60);
    pre_d   = pre_q;
    hh_d    = hh;
    mm_d    = mm;
    ss_d    = ss;
    sec_d   = 1'b0;
    day_d   = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    if (set_req) begin
      if (load_ok) begin
        hh_d  = set_hh;
        mm_d  = set_mm;
        ss_d  = set_ss;
        pre_d = '0;
        ack_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (run) begin
      if (tick) begin
        pre_d = '0;
        sec_d = 1'b1;
        if (ss == 6'd59) begin
          ss_d = 6'd0;
          if (mm == 6'd59) begin
            mm_d = 6'd0;
            if (hh == 5'd23) begin
              hh_d  = 5'd0;
              day_d = 1'b1;
            end else begin
              hh_d = hh + 5'd1;
            end
          end else begin
            mm_d = mm + 6'd1;
          end
        end else begin
          ss_d = ss + 6'd1;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  // Time, prescaler and status pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      hh        <= 5'd0;
      mm        <= 6'd0;
      ss        <= 6'd0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      set_ack   <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      hh        <= hh_d;
      mm        <= mm_d;
      ss        <= ss_d;
      sec_pulse <= sec_d;
      day_pulse <= day_d;
      set_ack   <= ack_d;
      set_err   <= err_d;
    end
  end

`ifdef TOD_ALARM_EN
  logic alarm_d;

  // Alarm fires only on a tick landing on hh:mm:00; out-of-range alarm fields never match
  always_comb begin
    alarm_d = sec_d && alarm_arm && (alarm_hh < 5'd24) && (alarm_mm < 6'd60) &&
              (hh_d == alarm_hh) && (mm_d == alarm_mm) && (ss_d == 6'd0);
  end

  // Registered alarm pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_hit <= 1'b0;
    end else begin
      alarm_hit <= alarm_d;
    end
  end
`else
  // Alarm inputs are ignored in this build
  wire unused_alarm = ^{alarm_arm, alarm_hh, alarm_mm};
  assign alarm_hit = 1'b0;
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Bench for tod_counter with TICKS_PER_SEC=4: seconds-of-day model plus
// directed scenarios with hand-computed expectations.
module tb_tod_counter;

  localparam int T = 4;
`ifdef TOD_ALARM_EN
  localparam bit ALM = 1'b1;
`else
  localparam bit ALM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       set_req = 1'b0;
  logic [4:0] set_hh = '0;
  logic [5:0] set_mm = '0;
  logic [5:0] set_ss = '0;
  logic       set_ack, set_err;
  logic [4:0] hh;
  logic [5:0] mm, ss;
  logic       sec_pulse, day_pulse;
  logic       alarm_arm = 1'b0;
  logic [4:0] alarm_hh = '0;
  logic [5:0] alarm_mm = '0;
  logic       alarm_hit;

  int checks = 0;
  int failures = 0;
  int sec_cnt = 0;
  int day_cnt = 0;

  // model state: time as seconds since midnight
  int m_tod = 0;
  int m_pre = 0;
  bit m_sec = 0, m_day = 0, m_ack = 0, m_err = 0, m_alm = 0;

  tod_counter #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .set_req(set_req),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .set_ack(set_ack), .set_err(set_err),
    .hh(hh), .mm(mm), .ss(ss),
    .sec_pulse(sec_pulse), .day_pulse(day_pulse),
    .alarm_arm(alarm_arm), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
    .alarm_hit(alarm_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tod = 0; m_pre = 0;
      m_sec = 0; m_day = 0; m_ack = 0; m_err = 0; m_alm = 0;
    end else begin
      m_sec = 0; m_day = 0; m_ack = 0; m_err = 0; m_alm = 0;
      if (set_req) begin
        if (int'(set_hh) < 24 && int'(set_mm) < 60 && int'(set_ss) < 60) begin
          m_tod = int'(set_hh) * 3600 + int'(set_mm) * 60 + int'(set_ss);
          m_pre = 0;
          m_ack = 1;
        end else begin
          m_err = 1;
        end
      end else if (run) begin
        if (m_pre == T - 1) begin
          m_pre = 0;
          m_tod = (m_tod + 1) % 86400;
          m_sec = 1;
          m_day = (m_tod == 0);
          m_alm = ALM && alarm_arm && int'(alarm_hh) < 24 && int'(alarm_mm) < 60 &&
                  (m_tod == int'(alarm_hh) * 3600 + int'(alarm_mm) * 60);
        end else begin
          m_pre++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse counters
  always @(negedge clk) begin
    chk("hh", int'(hh), m_tod / 3600);
    chk("mm", int'(mm), (m_tod / 60) % 60);
    chk("ss", int'(ss), m_tod % 60);
    chk("sec_pulse", int'(sec_pulse), int'(m_sec));
    chk("day_pulse", int'(day_pulse), int'(m_day));
    chk("set_ack", int'(set_ack), int'(m_ack));
    chk("set_err", int'(set_err), int'(m_err));
    chk("alarm_hit", int'(alarm_hit), int'(m_alm));
    if (sec_pulse) sec_cnt++;
    if (day_pulse) day_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic load(input int h, input int m, input int s);
    set_req = 1'b1;
    set_hh = 5'(h);
    set_mm = 6'(m);
    set_ss = 6'(s);
    cyc(1);
    set_req = 1'b0;
  endtask

  initial begin
    // reset state
    cyc(2);
    chk("rst_hh", int'(hh), 0);
    chk("rst_ss", int'(ss), 0);
    chk("rst_sec", int'(sec_pulse), 0);
    rst_n = 1'b1;
    run = 1'b1;
    sec_cnt = 0;
    cyc(12);
    chk("run12_ss", int'(ss), 3);
    chk("run12_mm", int'(mm), 0);
    chk("run12_secs", sec_cnt, 3);
    chk("run12_days", day_cnt, 0);

    // midnight wrap
    load(23, 59, 58);
    chk("load_ack", int'(set_ack), 1);
    chk("load_hh", int'(hh), 23);
    chk("load_ss", int'(ss), 58);
    cyc(8);
    chk("wrap_hh", int'(hh), 0);
    chk("wrap_mm", int'(mm), 0);
    chk("wrap_ss", int'(ss), 0);
    chk("wrap_day", int'(day_pulse), 1);
    chk("wrap_sec", int'(sec_pulse), 1);

    // rejected load leaves time alone
    run = 1'b0;
    load(1, 60, 0);
    chk("bad_err", int'(set_err), 1);
    chk("bad_ack", int'(set_ack), 0);
    chk("bad_hh", int'(hh), 0);
    run = 1'b1;
    cyc(3);
    // load on the tick edge wins
    load(12, 34, 56);
    chk("tickld_ack", int'(set_ack), 1);
    chk("tickld_sec", int'(sec_pulse), 0);
    chk("tickld_hh", int'(hh), 12);
    chk("tickld_ss", int'(ss), 56);
    cyc(3);
    chk("pre0_nosec", int'(sec_pulse), 0);
    cyc(1);
    chk("pre0_sec", int'(sec_pulse), 1);
    chk("pre0_ss", int'(ss), 57);

    // freeze mid-second
    cyc(2);
    run = 1'b0;
    cyc(10);
    chk("freeze_ss", int'(ss), 57);
    run = 1'b1;
    cyc(1);
    chk("resume1_sec", int'(sec_pulse), 0);
    cyc(1);
    chk("resume2_sec", int'(sec_pulse), 1);
    chk("resume2_ss", int'(ss), 58);

    // alarm armed at 00:01
    alarm_hh = 5'd0;
    alarm_mm = 6'd1;
    alarm_arm = 1'b1;
    load(0, 0, 59);
    cyc(3);
    chk("alm_early", int'(alarm_hit), 0);
    cyc(1);
    chk("alm_mm", int'(mm), 1);
    chk("alm_hit", int'(alarm_hit), int'(ALM));
    cyc(1);
    chk("alm_once", int'(alarm_hit), 0);
    // disarmed
    alarm_arm = 1'b0;
    load(0, 0, 59);
    cyc(4);
    chk("alm_disarmed", int'(alarm_hit), 0);
    // out-of-range alarm minute never hits
    alarm_arm = 1'b1;
    alarm_mm = 6'd60;
    load(0, 59, 59);
    cyc(4);
    chk("alm_oor_hh", int'(hh), 1);
    chk("alm_oor", int'(alarm_hit), 0);
    // load exactly at alarm time
    alarm_mm = 6'd1;
    load(0, 1, 0);
    chk("alm_load", int'(alarm_hit), 0);

    // held set_req reloads every cycle
    set_req = 1'b1;
    set_hh = 5'd5; set_mm = 6'd6; set_ss = 6'd7;
    cyc(1);
    chk("hold_ack1", int'(set_ack), 1);
    set_ss = 6'd8;
    cyc(1);
    chk("hold_ack2", int'(set_ack), 1);
    chk("hold_ss", int'(ss), 8);
    set_req = 1'b0;

    // reset at 23:59:59 with prescaler at 3
    load(23, 59, 59);
    cyc(3);
    rst_n = 1'b0;
    #1;
    chk("arst_hh", int'(hh), 0);
    chk("arst_ss", int'(ss), 0);
    chk("arst_day", int'(day_pulse), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    chk("rel_day", int'(day_pulse), 0);
    chk("rel_sec", int'(sec_pulse), 0);
    cyc(6);
    chk("total_days", day_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
